// File: rtl/ten_neurons_output_layer_pkg.sv
// Shared sizes, FSM state type and sign-magnitude arithmetic helpers for the
// MLP output layer.
package nn_pkg;

  localparam int N_IN  = 20;
  localparam int N_OUT = 10;
  localparam int W     = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_BIAS,
    S_DONE
  } state_t;

  // Byte layout: bit 7 is the sign, bits 6..0 the Q0.7 magnitude; 0x80 reads as 0.
  function automatic logic signed [15:0] sm2tc(input logic [7:0] b);
    logic signed [15:0] mag;
    mag = signed'({9'd0, b[6:0]});
    return b[7] ? -mag : mag;
  endfunction

  function automatic logic signed [15:0] sm_mul(input logic [7:0] a, input logic [7:0] b);
    logic [6:0] mag;
    mag = 7'(({7'd0, a[6:0]} * {7'd0, b[6:0]}) >> 7);
    return sm2tc({a[7] ^ b[7], mag});
  endfunction

  function automatic logic [7:0] tc2sm_sat(input logic signed [15:0] v);
    if (v > 16'sd127)
      return 8'h7F;
    if (v < -16'sd127)
      return 8'hFF;
    if (v < 16'sd0)
      return {1'b1, 7'(-v)};
    return {1'b0, 7'(v)};
  endfunction

  function automatic logic [7:0] relu_sat(input logic signed [15:0] v);
    if (v <= 16'sd0)
      return 8'h00;
    if (v > 16'sd127)
      return 8'h7F;
    return {1'b0, 7'(v)};
  endfunction

endpackage

// File: rtl/ten_neurons_output_layer_if.sv
// Operand/result bus between the hidden layer, this output layer and the
// argmax consumer.
interface ten_neurons_output_layer_if;
  import nn_pkg::*;

  logic                      start;
  logic                      received;
  logic [0:N_IN*W-1]         data;
  logic [0:N_OUT*N_IN*W-1]   weights;
  logic [0:N_OUT*W-1]        biases;
  logic [0:N_OUT*W-1]        neuron_out;
  logic [0:N_OUT*W-1]        NotUsed_neuron_out;
  logic                      R;

  modport master (
    output start, received, data, weights, biases,
    input  neuron_out, NotUsed_neuron_out, R
  );

  modport slave (
    input  start, received, data, weights, biases,
    output neuron_out, NotUsed_neuron_out, R
  );

endinterface

// File: rtl/ten_neurons_output_layer_output_neuron.sv
// One serial MAC neuron: accumulates one weight*activation product per cycle,
// then folds in the bias and registers ReLU and saturated pre-activation results.
module output_neuron
  import nn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        add_bias,
  input  logic [7:0]  weight,
  input  logic [7:0]  act,
  input  logic [7:0]  bias,
  output logic [7:0]  relu_out,
  output logic [7:0]  pre_out
);

  logic signed [15:0] acc;
  logic signed [15:0] term;
  logic signed [15:0] sum;

  // The adder is shared between product terms and the final bias term.
  always_comb begin
    term = '0;
    if (add_bias)
      term = sm2tc(bias);
    else
      term = sm_mul(weight, act);
    sum = acc + term;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      relu_out <= '0;
      pre_out  <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end else if (add_bias) begin
      acc      <= sum;
      relu_out <= relu_sat(sum);
      pre_out  <= tc2sm_sat(sum);
    end
  end

endmodule

// File: rtl/ten_neurons_output_layer.sv
// Ten-neuron output layer: latches operands on start, steps a shared input index
// through 20 MAC cycles, adds biases, and holds results with R until acknowledged.
module ten_neurons_output_layer
  import nn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ten_neurons_output_layer_if.slave bus
);

  state_t     state;
  state_t     state_nxt;
  logic       clr;
  logic       en;
  logic       add_bias;
  logic       load;
  logic [4:0] k;
  logic       r_q;

  logic [7:0] data_q   [N_IN];
  logic [7:0] weight_q [N_OUT][N_IN];
  logic [7:0] bias_q   [N_OUT];

  logic [7:0] act_sel;
  logic [7:0] weight_sel [N_OUT];
  logic [7:0] relu_arr   [N_OUT];
  logic [7:0] pre_arr    [N_OUT];
  logic [0:N_OUT*W-1] relu_flat;
  logic [0:N_OUT*W-1] pre_flat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Start is honoured only from IDLE or DONE, and beats received in DONE.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    en        = 1'b0;
    add_bias  = 1'b0;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_CALC;
          clr       = 1'b1;
          load      = 1'b1;
        end
      end
      S_CALC: begin
        en = 1'b1;
        if (k == 5'(N_IN - 1))
          state_nxt = S_BIAS;
      end
      S_BIAS: begin
        add_bias  = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.start) begin
          state_nxt = S_CALC;
          clr       = 1'b1;
          load      = 1'b1;
        end else if (bus.received) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      k <= '0;
    else if (clr)
      k <= '0;
    else if (en)
      k <= k + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_q <= 1'b0;
    else if (add_bias)
      r_q <= 1'b1;
    else if (state == S_DONE && (bus.start || bus.received))
      r_q <= 1'b0;
  end

  // Operand snapshot so the running computation ignores later input changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++)
        data_q[i] <= '0;
      for (int n = 0; n < N_OUT; n++) begin
        bias_q[n] <= '0;
        for (int i = 0; i < N_IN; i++)
          weight_q[n][i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < N_IN; i++)
        data_q[i] <= bus.data[W*i +: W];
      for (int n = 0; n < N_OUT; n++) begin
        bias_q[n] <= bus.biases[W*n +: W];
        for (int i = 0; i < N_IN; i++)
          weight_q[n][i] <= bus.weights[W*(N_IN*n + i) +: W];
      end
    end
  end

  always_comb begin
    act_sel = data_q[k];
    for (int n = 0; n < N_OUT; n++)
      weight_sel[n] = weight_q[n][k];
  end

  for (genvar n = 0; n < N_OUT; n++) begin : g_neuron
    output_neuron u_neuron (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .en       (en),
      .add_bias (add_bias),
      .weight   (weight_sel[n]),
      .act      (act_sel),
      .bias     (bias_q[n]),
      .relu_out (relu_arr[n]),
      .pre_out  (pre_arr[n])
    );
  end

  always_comb begin
    relu_flat = '0;
    pre_flat  = '0;
    for (int n = 0; n < N_OUT; n++) begin
      relu_flat[W*n +: W] = relu_arr[n];
      pre_flat[W*n +: W]  = pre_arr[n];
    end
  end

  assign bus.neuron_out         = relu_flat;
  assign bus.NotUsed_neuron_out = pre_flat;
  assign bus.R                  = r_q;

endmodule

// File: tb/tb_ten_neurons_output_layer.sv
// Scoreboard bench for the ten-neuron output layer: directed vectors with
// hand-computed results, checked by a monitor on each rising R.
module tb_ten_neurons_output_layer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic r_prev = 1'b0;

  typedef struct {
    logic [0:79] relu;
    logic [0:79] pre;
    int          rise_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  exp_relu [10];
  logic [7:0]  exp_pre  [10];
  logic [0:79] cur_relu;
  logic [0:79] cur_pre;

  ten_neurons_output_layer_if bus();

  ten_neurons_output_layer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string name, input logic [79:0] act, input logic [79:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkVal("latency_cycle", 80'(cyc), 80'(e.rise_cyc));
    for (int n = 0; n < 10; n++) begin
      checkVal($sformatf("neuron_out_n%0d", n), 80'(bus.neuron_out[8*n +: 8]), 80'(e.relu[8*n +: 8]));
      checkVal($sformatf("notused_n%0d", n), 80'(bus.NotUsed_neuron_out[8*n +: 8]), 80'(e.pre[8*n +: 8]));
    end
  endtask

  // Scoreboard monitor: every rising R must match the oldest outstanding run.
  always @(negedge clk) begin
    if (!rst && bus.R && !r_prev) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_R: got R=1 expected no result pending at cycle %0d", cyc);
      end else begin
        checkOutput(sb.pop_front());
      end
    end
    r_prev = bus.R;
  end

  task automatic setData(input int k, input logic [7:0] b);
    bus.data[8*k +: 8] = b;
  endtask

  task automatic setWeight(input int n, input int k, input logic [7:0] b);
    bus.weights[8*(20*n + k) +: 8] = b;
  endtask

  task automatic setBias(input int n, input logic [7:0] b);
    bus.biases[8*n +: 8] = b;
  endtask

  // Vectors: 0 bias pass-through, 1 single term, 2 saturation, 3 negatives/bias mix.
  task automatic loadVector(input int id);
    bus.data    = '0;
    bus.weights = '0;
    bus.biases  = '0;
    for (int n = 0; n < 10; n++) begin
      exp_relu[n] = 8'h00;
      exp_pre[n]  = 8'h00;
    end
    case (id)
      0: begin
        for (int n = 0; n < 10; n++) begin
          setBias(n, 8'h05);
          exp_relu[n] = 8'h05;
          exp_pre[n]  = 8'h05;
        end
      end
      1: begin
        setData(0, 8'h40);
        setWeight(3, 0, 8'h40);
        exp_relu[3] = 8'h20;
        exp_pre[3]  = 8'h20;
      end
      2: begin
        for (int k = 0; k < 20; k++) begin
          setData(k, 8'h7F);
          setWeight(1, k, 8'h7F);
          setWeight(2, k, 8'hFF);
        end
        exp_relu[1] = 8'h7F;
        exp_pre[1]  = 8'h7F;
        exp_relu[2] = 8'h00;
        exp_pre[2]  = 8'hFF;
      end
      default: begin
        setData(0, 8'h40);
        setWeight(0, 0, 8'hC0);
        setWeight(6, 0, 8'h40);
        setBias(4, 8'h85);
        setBias(5, 8'h80);
        setBias(6, 8'h05);
        exp_pre[0]  = 8'hA0;
        exp_pre[4]  = 8'h85;
        exp_relu[6] = 8'h25;
        exp_pre[6]  = 8'h25;
      end
    endcase
  endtask

  task automatic scrambleInputs();
    for (int k = 0; k < 20; k++) begin
      setData(k, 8'h00);
      setWeight(1, k, 8'h00);
    end
    bus.biases = {10{8'h11}};
  endtask

  // Called at a negedge; start is sampled on the following posedge (edge 0).
  task automatic applyStimulus(input logic with_ack);
    exp_t e;
    for (int n = 0; n < 10; n++) begin
      e.relu[8*n +: 8] = exp_relu[n];
      e.pre[8*n +: 8]  = exp_pre[n];
    end
    e.rise_cyc   = cyc + 22;
    cur_relu     = e.relu;
    cur_pre      = e.pre;
    sb.push_back(e);
    bus.start    = 1'b1;
    bus.received = with_ack;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.received = 1'b0;
  endtask

  task automatic waitForR(input int budget);
    int n = 0;
    while (!bus.R && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkVal("r_rise_within_budget", 80'(bus.R), 80'(1));
  endtask

  task automatic ackAndCheck();
    bus.received = 1'b1;
    @(negedge clk);
    bus.received = 1'b0;
    checkVal("r_after_ack", 80'(bus.R), 80'(0));
    checkVal("neuron_out_after_ack", 80'(bus.neuron_out), 80'(cur_relu));
    checkVal("notused_after_ack", 80'(bus.NotUsed_neuron_out), 80'(cur_pre));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.received = 1'b0;
    bus.data     = '0;
    bus.weights  = '0;
    bus.biases   = '0;
    repeat (3) @(negedge clk);
    checkVal("reset_R", 80'(bus.R), 80'(0));
    checkVal("reset_neuron_out", 80'(bus.neuron_out), 80'(0));
    checkVal("reset_notused", 80'(bus.NotUsed_neuron_out), 80'(0));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] bias pass-through");
    loadVector(0);
    applyStimulus(1'b0);
    waitForR(40);
    ackAndCheck();
    @(negedge clk);

    $display("[TB] single term, ignored start in CALC, hold and acknowledge");
    loadVector(1);
    applyStimulus(1'b0);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitForR(40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkVal($sformatf("hold_R_%0d", i), 80'(bus.R), 80'(1));
      checkVal($sformatf("hold_neuron_out_%0d", i), 80'(bus.neuron_out), 80'(cur_relu));
      checkVal($sformatf("hold_notused_%0d", i), 80'(bus.NotUsed_neuron_out), 80'(cur_pre));
    end
    ackAndCheck();
    @(negedge clk);

    $display("[TB] negative products and bias signs");
    loadVector(3);
    applyStimulus(1'b0);
    waitForR(40);
    repeat (2) @(negedge clk);

    $display("[TB] start with received in DONE, inputs changed mid-run");
    loadVector(2);
    applyStimulus(1'b1);
    checkVal("r_cleared_on_restart", 80'(bus.R), 80'(0));
    repeat (5) @(negedge clk);
    scrambleInputs();
    waitForR(40);
    ackAndCheck();
    @(negedge clk);

    $display("[TB] reset mid-run");
    loadVector(0);
    applyStimulus(1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    checkVal("midrun_reset_R", 80'(bus.R), 80'(0));
    checkVal("midrun_reset_neuron_out", 80'(bus.neuron_out), 80'(0));
    checkVal("midrun_reset_notused", 80'(bus.NotUsed_neuron_out), 80'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    loadVector(3);
    applyStimulus(1'b0);
    waitForR(40);
    ackAndCheck();

    repeat (30) @(negedge clk);
    checkVal("scoreboard_drained", 80'(sb.size()), 80'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
